video_timing_gen: RTL and testbench

- Generates the raster scan that drives the sprite compositors: pixel coordinates, sync, data-enable and frame markers.
- Sits directly upstream of every compositor. o_x/o_y feed the compositors' i_x/i_y; o_v_sync feeds i_v_sync.
- Defaults to 1920x1080@60 CEA timing (148.5 MHz pixel rate). An optional pixel enable supports divided pixel clocks.

---
 rtl/video_timing_pkg.sv | 33 +++
 rtl/video_axis_counter.sv | 56 +++++
 rtl/video_timing_gen.sv | 113 +++++++++++
 tb/tb_video_timing_gen.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and timing constants for the raster timing generator.
// Holds the CEA-861 1080p60 defaults and a reduced set for quick simulation.
package video_timing_pkg;

  typedef logic [15:0] coord_t;

  // CEA-861 1920x1080 @ 60 Hz, 148.5 MHz pixel clock
  localparam int CEA_H_ACTIVE = 1920;
  localparam int CEA_H_FP     = 88;
  localparam int CEA_H_SYNC   = 44;
  localparam int CEA_H_BP     = 148;
  localparam int CEA_V_ACTIVE = 1080;
  localparam int CEA_V_FP     = 4;
  localparam int CEA_V_SYNC   = 5;
  localparam int CEA_V_BP     = 36;

  // Tiny raster so whole frames fit in a short simulation
  localparam int SIM_H_ACTIVE = 16;
  localparam int SIM_H_FP     = 2;
  localparam int SIM_H_SYNC   = 2;
  localparam int SIM_H_BP     = 2;
  localparam int SIM_V_ACTIVE = 8;
  localparam int SIM_V_FP     = 1;
  localparam int SIM_V_SYNC   = 1;
  localparam int SIM_V_BP     = 1;

  localparam int COORD_MAX = 65535;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: a wrapping position counter with registered active/sync decodes.
// The decodes are taken from the next-state count so they line up with o_count.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int TOTAL      = 2200,
  parameter int SYNC_START = 2008,
  parameter int SYNC_END   = 2052,
  parameter int ACTIVE     = 1920
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [15:0] o_count,
  output logic        o_wrap,
  output logic        o_in_active,
  output logic        o_in_sync
);

  localparam coord_t LAST     = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END  = coord_t'(ACTIVE);
  localparam coord_t SYNC_BEG = coord_t'(SYNC_START);
  localparam coord_t SYNC_STP = coord_t'(SYNC_END);

  coord_t count_q, count_d;
  logic   active_q, active_d;
  logic   sync_q, sync_d;

  always_comb begin
    count_d = count_q;
    if (i_en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 16'd1;
    end
    active_d = (count_d < ACT_END);
    sync_d   = (count_d >= SYNC_BEG) && (count_d < SYNC_STP);
  end

  // Reset parks the axis on its last position so the first advance lands on 0
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q  <= LAST;
      active_q <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      sync_q   <= sync_d;
    end
  end

  assign o_count     = count_q;
  assign o_wrap      = (count_q == LAST);
  assign o_in_active = active_q;
  assign o_in_sync   = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates, syncs, data-enable and line/frame markers
// for the sprite compositors, with an optional pixel-advance enable.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = CEA_H_ACTIVE,
  parameter int   H_FP     = CEA_H_FP,
  parameter int   H_SYNC   = CEA_H_SYNC,
  parameter int   H_BP     = CEA_H_BP,
  parameter int   V_ACTIVE = CEA_V_ACTIVE,
  parameter int   V_FP     = CEA_V_FP,
  parameter int   V_SYNC   = CEA_V_SYNC,
  parameter int   V_BP     = CEA_V_BP,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_en,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_de,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic [15:0] o_frame_count
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_total_range
    $error("video_timing_gen: raster totals exceed the 16-bit coordinate range");
  end

  logic   h_wrap, h_active, h_in_sync;
  logic   v_wrap, v_active, v_in_sync;
  logic   v_en;
  coord_t h_count, v_count;

  assign v_en = i_pix_en && h_wrap;

  video_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC),
    .ACTIVE     (H_ACTIVE)
  ) u_h_axis (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_pix_en),
    .o_count     (h_count),
    .o_wrap      (h_wrap),
    .o_in_active (h_active),
    .o_in_sync   (h_in_sync)
  );

  // Vertical axis only moves on the x wrap, so v_sync edges fall on x=0
  video_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC),
    .ACTIVE     (V_ACTIVE)
  ) u_v_axis (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (v_en),
    .o_count     (v_count),
    .o_wrap      (v_wrap),
    .o_in_active (v_active),
    .o_in_sync   (v_in_sync)
  );

  logic   line_start_q, line_start_d;
  logic   frame_start_q, frame_start_d;
  logic   first_q, first_d;
  coord_t frame_cnt_q, frame_cnt_d;

  // The first frame after reset is frame 0; only later (0,0) entries count
  always_comb begin
    line_start_d  = v_en;
    frame_start_d = v_en && v_wrap;
    first_d       = first_q && !frame_start_d;
    frame_cnt_d   = frame_cnt_q;
    if (frame_start_d && !first_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      first_q       <= 1'b1;
      frame_cnt_q   <= '0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      first_q       <= first_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign o_x           = h_count;
  assign o_y           = v_count;
  assign o_de          = h_active && v_active;
  assign o_h_sync      = SYNC_POL ? h_in_sync : !h_in_sync;
  assign o_v_sync      = SYNC_POL ? v_in_sync : !v_in_sync;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small inverted-polarity raster and the default 1080p raster
// run side by side against a linear-pixel-index reference model.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] fc;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] s_x, s_y, s_fc, h_x, h_y, h_fc;
  logic        s_hs, s_vs, s_de, s_ls, s_fs;
  logic        h_hs, h_vs, h_de, h_ls, h_fs;

  video_timing_gen #(
    .H_ACTIVE (SIM_H_ACTIVE), .H_FP (SIM_H_FP), .H_SYNC (SIM_H_SYNC), .H_BP (SIM_H_BP),
    .V_ACTIVE (SIM_V_ACTIVE), .V_FP (SIM_V_FP), .V_SYNC (SIM_V_SYNC), .V_BP (SIM_V_BP),
    .SYNC_POL (1'b0)
  ) dut_s (
    .i_clk (clk), .i_rst_n (rst_n), .i_pix_en (pix_en),
    .o_x (s_x), .o_y (s_y), .o_h_sync (s_hs), .o_v_sync (s_vs), .o_de (s_de),
    .o_line_start (s_ls), .o_frame_start (s_fs), .o_frame_count (s_fc)
  );

  video_timing_gen dut_h (
    .i_clk (clk), .i_rst_n (rst_n), .i_pix_en (pix_en),
    .o_x (h_x), .o_y (h_y), .o_h_sync (h_hs), .o_v_sync (h_vs), .o_de (h_de),
    .o_line_start (h_ls), .o_frame_start (h_fs), .o_frame_count (h_fc)
  );

  int          total_n = 0;
  int          bad_n = 0;
  longint      n = 0;          // enabled edges since the last reset
  bit          last_en = 1'b0; // previous edge advanced the raster
  logic [15:0] off_s = 16'd0;  // frame-count preload on the small instance

  // Position n-1 along the linear scan of the raster; n=0 is the parked reset state
  function automatic exp_t model(input longint k, input bit last,
                                 input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input bit pol, input logic [15:0] off);
    exp_t   e;
    longint ht, vt, p, px, py;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (k == 0) begin
      e.x = 16'(ht - 1); e.y = 16'(vt - 1); e.fc = off;
      e.hs = !pol; e.vs = !pol; e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
    end else begin
      p  = (k - 1) % (ht * vt);
      px = p % ht;
      py = p / ht;
      e.x  = 16'(px);
      e.y  = 16'(py);
      e.fc = 16'(longint'(off) + (k - 1) / (ht * vt));
      e.de = (px < ha) && (py < va);
      e.hs = ((px >= ha + hfp) && (px < ha + hfp + hsw)) ? pol : !pol;
      e.vs = ((py >= va + vfp) && (py < va + vfp + vsw)) ? pol : !pol;
      e.ls = last && (px == 0);
      e.fs = last && (p == 0);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_dut(input string p, input exp_t o, input exp_t e);
    check({p, ".x"},  o.x,  e.x);
    check({p, ".y"},  o.y,  e.y);
    check({p, ".fc"}, o.fc, e.fc);
    check({p, ".hs"}, 16'(o.hs), 16'(e.hs));
    check({p, ".vs"}, 16'(o.vs), 16'(e.vs));
    check({p, ".de"}, 16'(o.de), 16'(e.de));
    check({p, ".ls"}, 16'(o.ls), 16'(e.ls));
    check({p, ".fs"}, 16'(o.fs), 16'(e.fs));
  endtask

  task automatic compare_all();
    exp_t os, oh;
    os = '{x: s_x, y: s_y, fc: s_fc, hs: s_hs, vs: s_vs, de: s_de, ls: s_ls, fs: s_fs};
    oh = '{x: h_x, y: h_y, fc: h_fc, hs: h_hs, vs: h_vs, de: h_de, ls: h_ls, fs: h_fs};
    check_dut("small", os, model(n, last_en, SIM_H_ACTIVE, SIM_H_FP, SIM_H_SYNC, SIM_H_BP,
                                 SIM_V_ACTIVE, SIM_V_FP, SIM_V_SYNC, SIM_V_BP, 1'b0, off_s));
    check_dut("hd", oh, model(n, last_en, CEA_H_ACTIVE, CEA_H_FP, CEA_H_SYNC, CEA_H_BP,
                              CEA_V_ACTIVE, CEA_V_FP, CEA_V_SYNC, CEA_V_BP, 1'b1, 16'd0));
  endtask

  // Drive on the falling edge, let the rising edge act, check on the next falling edge
  task automatic step(input logic en, input logic rn);
    pix_en = en;
    rst_n  = rn;
    @(posedge clk);
    if (!rn) begin
      n = 0; last_en = 1'b0; off_s = 16'd0;
    end else if (en) begin
      n++; last_en = 1'b1;
    end else begin
      last_en = 1'b0;
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Free run: several small frames and the first 1080p line plus its wrap
    for (int i = 0; i < 2300; i++) step(1'b1, 1'b1);

    // Alternating enable, then random enable
    for (int i = 0; i < 60; i++) step(logic'(i % 2 == 0), 1'b1);
    for (int i = 0; i < 600; i++) step(logic'($urandom_range(0, 1)), 1'b1);

    // Mid-frame reset, random length, then restart
    begin
      int rl;
      rl = int'($urandom_range(1, 3));
      for (int i = 0; i < rl; i++) step(1'b1, 1'b0);
    end
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1);

    // Preload the small instance's frame counter near its limit to see it wrap
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    force dut_s.frame_cnt_q = 16'hfffe;
    #1;
    release dut_s.frame_cnt_q;
    off_s = 16'hfffe;
    step(1'b0, 1'b1);
    for (int i = 0; i < 800; i++) step(1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
